// File: rtl/reg_file_32x32_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_32x32_pkg
// Shared datapath definitions for the register file, the control unit and the
// RegDst / MemtoReg muxes:
//   REGFILE_DW  data width (32)
//   REGFILE_AW  register address width (5), depth = 2**REGFILE_AW
//   REG_ZERO    hardwired-zero register index
//   REG_SP      MIPS stack pointer alias ($29)
//   REG_RA      MIPS return address alias ($31)
// -----------------------------------------------------------------------------
package reg_file_32x32_pkg;

  localparam int REGFILE_DW = 32;
  localparam int REGFILE_AW = 5;

  localparam logic [REGFILE_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REGFILE_AW-1:0] REG_SP   = 5'd29;
  localparam logic [REGFILE_AW-1:0] REG_RA   = 5'd31;

endpackage : reg_file_32x32_pkg

// File: rtl/reg_file_32x32.sv
// -----------------------------------------------------------------------------
// reg_file_32x32
// MIPS-style 32 x 32-bit register file, two combinational read ports and one
// synchronous write port. Register 0 always reads as zero.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset; clears every register, beats we
//   we       write enable (RegWrite)
//   waddr    write address (RegDst mux output)
//   wdata    write data (MemtoReg mux output)
//   raddr1   read address, port 1 (rs)
//   raddr2   read address, port 2 (rt)
//   rdata1   read data, port 1
//   rdata2   read data, port 2
//
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, a read that hits the address being
//                      written this cycle returns wdata (write-through);
//                      when undefined, the read returns the stored value
//                      until the write edge.
// -----------------------------------------------------------------------------
module reg_file_32x32
  import reg_file_32x32_pkg::*;
#(
  parameter int DW = REGFILE_DW,
  parameter int AW = REGFILE_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  localparam int DEPTH = 2 ** AW;

`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  logic [DW-1:0] regs_r [0:DEPTH-1];

  logic          write_fire_s;
  logic          hit1_s;
  logic          hit2_s;

  // Zero register first, then same-cycle forwarding, then the stored word.
  function automatic logic [DW-1:0] read_port(
    input logic [AW-1:0] raddr,
    input logic [DW-1:0] stored,
    input logic          bypass_hit,
    input logic [DW-1:0] bypass_data
  );
    logic [DW-1:0] result;
    if (raddr == {AW{1'b0}}) begin
      result = {DW{1'b0}};
    end else if (bypass_hit) begin
      result = bypass_data;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  // A write only lands out of reset and never on register 0.
  always_comb begin
    write_fire_s = reset_n & we & (waddr != {AW{1'b0}});
  end

  // Forwarding hits; tied off in the non-bypass build through BYPASS_EN.
  always_comb begin
    hit1_s = BYPASS_EN & write_fire_s & (raddr1 == waddr);
    hit2_s = BYPASS_EN & write_fire_s & (raddr2 == waddr);
  end

  // Storage: synchronous clear on reset, otherwise the single write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else if (write_fire_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Both read ports share the same selection logic.
  always_comb begin
    rdata1 = read_port(raddr1, regs_r[raddr1], hit1_s, wdata);
    rdata2 = read_port(raddr2, regs_r[raddr2], hit2_s, wdata);
  end

endmodule : reg_file_32x32
